// File: rtl/dcache_refill_ctrl.sv
// D-cache miss sequencer: optional dirty-victim write-back, then a beat-wise
// line fetch that is assembled locally and written to the data RAM in one cycle.
module dcache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 6,
  parameter int LINE_WIDTH  = 256,
  parameter int WEA_WIDTH   = LINE_WIDTH / 8,
  parameter int BEAT_WIDTH  = 64,
  parameter int PADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   miss_valid,
  output logic                   miss_ready,
  input  logic [ADDR_WIDTH-1:0]  miss_index,
  input  logic [PADDR_WIDTH-1:0] miss_addr,
  input  logic                   miss_dirty,
  input  logic [PADDR_WIDTH-1:0] victim_addr,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  done_index,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  ram_addra,
  output logic                   ram_ena,
  output logic [WEA_WIDTH-1:0]   ram_wea,
  output logic [LINE_WIDTH-1:0]  ram_dina,
  output logic [ADDR_WIDTH-1:0]  ram_addrb,
  output logic                   ram_enb,
  input  logic [LINE_WIDTH-1:0]  ram_doutb,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [PADDR_WIDTH-1:0] wb_addr,
  output logic [LINE_WIDTH-1:0]  wb_data,
  output logic                   rd_req_valid,
  input  logic                   rd_req_ready,
  output logic [PADDR_WIDTH-1:0] rd_req_addr,
  input  logic                   rd_resp_valid,
  input  logic [BEAT_WIDTH-1:0]  rd_resp_data
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VREAD = 3'd1;
  localparam logic [2:0] S_VCAP  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_RREQ  = 3'd4;
  localparam logic [2:0] S_RFILL = 3'd5;
  localparam logic [2:0] S_WRITE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [PADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [PADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // line_q holds the victim during write-back, then is reused to assemble the refill
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    maddr_d = maddr_q;
    vaddr_d = vaddr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (miss_valid) begin
        idx_d   = miss_index;
        maddr_d = miss_addr;
        vaddr_d = victim_addr;
        state_d = miss_dirty ? S_VREAD : S_RREQ;
      end
      S_VREAD: state_d = S_VCAP;
      S_VCAP: begin
        line_d  = ram_doutb;
        state_d = S_WB;
      end
      S_WB: if (wb_ready) state_d = S_RREQ;
      S_RREQ: if (rd_req_ready) begin
        cnt_d   = '0;
        state_d = S_RFILL;
      end
      S_RFILL: if (rd_resp_valid) begin
        line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = rd_resp_data;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      maddr_q <= '0;
      vaddr_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      maddr_q <= maddr_d;
      vaddr_q <= vaddr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are pure state decodes, gated to zero outside their owning state
  assign miss_ready   = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ram_enb      = (state_q == S_VREAD);
  assign ram_addrb    = ram_enb ? idx_q : '0;
  assign wb_valid     = (state_q == S_WB);
  assign wb_addr      = wb_valid ? vaddr_q : '0;
  assign wb_data      = wb_valid ? line_q : '0;
  assign rd_req_valid = (state_q == S_RREQ);
  assign rd_req_addr  = rd_req_valid ? maddr_q : '0;
  assign ram_ena      = (state_q == S_WRITE);
  assign ram_wea      = ram_ena ? '1 : '0;
  assign ram_addra    = ram_ena ? idx_q : '0;
  assign ram_dina     = ram_ena ? line_q : '0;
  assign done         = (state_q == S_DONE);
  assign done_index   = done ? idx_q : '0;

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Miss-handling sequencer for the D-cache data array, a simple-dual-port sync RAM with one full line per word: port A write with byte enables, port B read with 1-cycle latency.
- Accepts one miss at a time from the cache pipeline.
- If the victim is dirty, reads it out through port B and writes it back to memory, then fetches the new line in beats and writes it through port A.
- Sits between the D-cache pipeline, the data RAM and the memory interface.

Parameters:
- ADDR_WIDTH, 6, data RAM line index width.
- LINE_WIDTH, 256, bits per cache line and RAM word.
- WEA_WIDTH, LINE_WIDTH/8, RAM byte-enable width.
- BEAT_WIDTH, 64, memory read-response beat width; LINE_WIDTH must be a multiple of it.
- PADDR_WIDTH, 32, physical address width; addresses are line-aligned.

Ports:
- clk  in  1  common clock
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  miss request
- miss_ready  out  1  controller can accept a miss
- miss_index  in  ADDR_WIDTH  RAM line index to refill
- miss_addr  in  PADDR_WIDTH  line address to fetch
- miss_dirty  in  1  victim line must be written back
- victim_addr  in  PADDR_WIDTH  write-back address of the victim
- done  out  1  one-cycle pulse: refill written
- done_index  out  ADDR_WIDTH  index of the completed refill, valid with done
- busy  out  1  a miss is in progress
- ram_addra  out  ADDR_WIDTH  RAM write address
- ram_ena  out  1  RAM write enable (port)
- ram_wea  out  WEA_WIDTH  RAM byte enables
- ram_dina  out  LINE_WIDTH  RAM write data
- ram_addrb  out  ADDR_WIDTH  RAM read address
- ram_enb  out  1  RAM read enable
- ram_doutb  in  LINE_WIDTH  RAM read data, 1 cycle after enb
- wb_valid  out  1  write-back request
- wb_ready  in  1  memory accepts write-back
- wb_addr  out  PADDR_WIDTH  write-back address
- wb_data  out  LINE_WIDTH  write-back line
- rd_req_valid  out  1  line fetch request
- rd_req_ready  in  1  memory accepts fetch
- rd_req_addr  out  PADDR_WIDTH  fetch address
- rd_resp_valid  in  1  response beat valid; always accepted, no backpressure
- rd_resp_data  in  BEAT_WIDTH  response beat

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all outputs 0 except miss_ready=1.
  - Internal index, address, line and beat-counter registers cleared.
  - Reset mid-operation abandons the miss: no RAM write, no done pulse.
- BEATS = LINE_WIDTH/BEAT_WIDTH. The beat counter is clog2(BEATS) bits, minimum 1.
- States and transitions:
  - IDLE: miss_ready=1. On miss_valid, latch index, miss_addr, victim_addr and dirty. Go to VREAD if dirty, else RREQ. miss_ready=0 in every other state.
  - VREAD: ram_enb=1, ram_addrb=latched index for exactly one cycle -> VCAP.
  - VCAP: capture ram_doutb into the line register -> WB.
  - WB: wb_valid=1, wb_addr=victim_addr, wb_data=line register, all held stable until wb_ready. Transfer when wb_valid&&wb_ready -> RREQ.
  - RREQ: rd_req_valid=1, rd_req_addr=latched miss_addr, held until rd_req_ready. On transfer, clear the beat counter -> RFILL.
  - RFILL: each rd_resp_valid writes rd_resp_data into line bits [k*BEAT_WIDTH +: BEAT_WIDTH], with beat k=counter, then increments the counter. On beat BEATS-1 -> WRITE. Beats are little-endian: first beat is the lowest bits.
  - WRITE: ram_ena=1, ram_wea=all ones, ram_addra=index, ram_dina=assembled line for exactly one cycle -> DONE.
  - DONE: done=1, done_index=index for one cycle, busy=0 -> IDLE. miss_ready returns to 1 the cycle after DONE.
- busy=1 in every state except IDLE and DONE.
- ram_ena/ram_enb are 0 outside WRITE/VREAD; ram_wea=0 whenever ram_ena=0.
- Port B is never read in the same cycle port A writes, so no read-during-write hazard.
- rd_resp_valid outside RFILL is ignored. wb_ready/rd_req_ready outside their states are ignored.
- A miss_valid arriving while not in IDLE is not accepted; the requester holds it.
- Minimum latency from acceptance to done:
  - clean victim: 1 (RREQ) + BEATS + 1 (WRITE) + 1 (DONE) cycles, with ready/valid asserted immediately.
  - dirty victim: adds 3 cycles (VREAD, VCAP, WB).

Test Plan:
- Clean miss: index 5, addr 0x1000, BEATS=4, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> one rd_req at 0x1000; single ram_ena cycle at addra 5 with wea all ones and dina={0x44..,0x33..,0x22..,0x11..}; done with done_index 5 one cycle later.
- Dirty miss: RAM[9] preloaded 0xDEAD.., victim_addr 0x2000 -> enb at 9; wb_valid with wb_addr 0x2000, wb_data 0xDEAD..; rd_req issued only after the wb handshake; refill written to 9.
- Backpressure: wb_ready held low 5 cycles and rd_req_ready low 3 -> wb/rd_req outputs stable throughout; exactly one transfer each; miss_ready stays 0.
- Gapped response: beats with 2-cycle bubbles; stray rd_resp_valid pulses in WB -> stray beats ignored; line assembled correctly; single write.
- Reset during RFILL after 2 beats -> all outputs 0 and miss_ready=1 immediately; no ram_ena and no done; a subsequent new miss completes normally.
- Back-to-back misses: second miss_valid held during the first -> accepted the cycle after DONE; two done pulses with the correct indices.
